// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default receive FIFO depth and byte type.
package uart_pkg;
  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side valid/ready read port of the receive FIFO.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
);
  logic                  o_Rd_Valid;
  logic [DATA_WIDTH-1:0] o_Rd_Byte;
  logic                  i_Rd_Ready;

  modport master (output o_Rd_Valid, output o_Rd_Byte, input i_Rd_Ready);
  modport slave  (input o_Rd_Valid, input o_Rd_Byte, output i_Rd_Ready);
endinterface

// File: rtl/uart_pulse_sync.sv
// Synchronizes a slow strobe into the clk domain and emits a one-cycle pulse
// on each rising edge of it.
module uart_pulse_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: captures each synchronized done strobe's byte and serves
// it show-ahead on a valid/ready port, with a sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = UART_FIFO_DEPTH,
  parameter int unsigned DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_Rx_Done,
  input  logic [DATA_WIDTH-1:0]    i_Rx_Byte,
  uart_rx_fifo_if.master           rd_if,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic                     o_Overflow,
  input  logic                     i_Clear_Overflow
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  push;
  logic                  do_push;
  logic                  do_pop;
  logic                  drop;

  uart_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_done_sync (
    .clk   (clk),
    .reset (reset),
    .din   (i_Rx_Done),
    .pulse (push)
  );

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign o_Empty = (wr_ptr == rd_ptr);
  assign o_Full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_Count = wr_ptr - rd_ptr;

  assign do_pop  = ~o_Empty & rd_if.i_Rd_Ready;
  assign do_push = push & (~o_Full | do_pop);
  assign drop    = push & o_Full & ~do_pop;

  assign rd_if.o_Rd_Valid = ~o_Empty;
  assign rd_if.o_Rd_Byte  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)
        o_Overflow <= 1'b1;
      else if (i_Clear_Overflow)
        o_Overflow <= 1'b0;
    end
  end

  // Storage has no reset so it stays a plain register array.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_Rx_Byte;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo against a queue-based model plus directed literal checks.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned SYNC  = 2;

  logic       clk;
  logic       reset;
  logic       rx_done;
  uart_byte_t rx_byte;
  logic       clear_ovf;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       ovf;

  uart_rx_fifo_if #(.DATA_WIDTH(8)) rd_if ();

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(8), .SYNC_STAGES(SYNC)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_Rx_Done        (rx_done),
    .i_Rx_Byte        (rx_byte),
    .rd_if            (rd_if),
    .o_Count          (count),
    .o_Full           (full),
    .o_Empty          (empty),
    .o_Overflow       (ovf),
    .i_Clear_Overflow (clear_ovf)
  );

  int tests = 0;
  int fails = 0;

  // Model: byte queue plus a list of scheduled arrival edges.
  uart_byte_t  q[$];
  int unsigned pend_cyc[$];
  uart_byte_t  pend_byte[$];
  bit          m_ovf = 0;
  int unsigned cyc = 0;
  bit          check_en = 0;
  bit          rand_ready = 0;

  bit          m_pop, m_push, m_drop;
  int          m_sz;
  uart_byte_t  m_b;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout act=%0d req=finish", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=0x%0h req=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      pend_cyc.delete();
      pend_byte.delete();
      m_ovf = 0;
    end else begin
      m_sz   = q.size();
      m_pop  = (m_sz != 0) && (rd_if.i_Rd_Ready === 1'b1);
      m_push = 0;
      m_b    = '0;
      if (pend_cyc.size() != 0 && pend_cyc[0] == cyc) begin
        m_push = 1;
        m_b    = pend_byte[0];
        void'(pend_cyc.pop_front());
        void'(pend_byte.pop_front());
      end
      m_drop = m_push && (m_sz == DEPTH) && !m_pop;
      if (m_pop) void'(q.pop_front());
      if (m_push && !m_drop) q.push_back(m_b);
      if (m_drop) m_ovf = 1;
      else if (clear_ovf) m_ovf = 0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      if (reset) begin
        chk("rst_valid", int'(rd_if.o_Rd_Valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_ovf", int'(ovf), 0);
      end else begin
        chk("valid", int'(rd_if.o_Rd_Valid), int'(q.size() != 0));
        chk("count", int'(count), q.size());
        chk("full", int'(full), int'(q.size() == DEPTH));
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("count_range", int'(count <= 5'd16), 1);
        if (q.size() != 0) chk("rd_byte", int'(rd_if.o_Rd_Byte), int'(q[0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) rd_if.i_Rd_Ready = 1'($urandom_range(0, 1));
  endtask

  task automatic strobe_rise(input uart_byte_t b);
    rx_byte = b;
    rx_done = 1'b1;
    pend_cyc.push_back(cyc + SYNC + 1);
    pend_byte.push_back(b);
  endtask

  task automatic frame(input uart_byte_t b, input int unsigned w, input int unsigned gap);
    strobe_rise(b);
    repeat (w) tick();
    rx_done = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic drain(output uart_byte_t last);
    int n;
    n = 0;
    last = '0;
    rd_if.i_Rd_Ready = 1'b1;
    while (rd_if.o_Rd_Valid === 1'b1 && n < 40) begin
      last = rd_if.o_Rd_Byte;
      tick();
      n++;
    end
    rd_if.i_Rd_Ready = 1'b0;
    chk("drain_bound", int'(rd_if.o_Rd_Valid), 0);
  endtask

  uart_byte_t last;

  initial begin
    reset = 1'b1;
    rx_done = 1'b0;
    rx_byte = '0;
    clear_ovf = 1'b0;
    rd_if.i_Rd_Ready = 1'b0;
    repeat (3) tick();
    check_en = 1;
    chk("lit_rst_empty", int'(empty), 1);
    chk("lit_rst_full", int'(full), 0);
    reset = 1'b0;
    tick();

    // Single wide strobe: one entry, visible three edges after first sample.
    strobe_rise(8'hA5);
    tick();
    chk("lit_lat_e1", int'(rd_if.o_Rd_Valid), 0);
    tick();
    chk("lit_lat_e2", int'(rd_if.o_Rd_Valid), 0);
    tick();
    chk("lit_lat_e3", int'(rd_if.o_Rd_Valid), 1);
    chk("lit_a5", int'(rd_if.o_Rd_Byte), 8'hA5);
    repeat (2) tick();
    rx_done = 1'b0;
    repeat (3) tick();
    chk("lit_one_entry", int'(count), 1);
    chk("lit_model_one", q.size(), 1);
    rd_if.i_Rd_Ready = 1'b1;
    tick();
    rd_if.i_Rd_Ready = 1'b0;
    chk("lit_pop_empty", int'(empty), 1);

    // Fill, overflow, clear, clear-vs-drop, drain.
    for (int i = 0; i < 16; i++) frame(8'(i), $urandom_range(1, 4), 3);
    chk("lit_full", int'(full), 1);
    chk("lit_count16", int'(count), 16);
    frame(8'hEE, 2, 3);
    chk("lit_ovf_set", int'(ovf), 1);
    repeat (3) tick();
    chk("lit_ovf_sticky", int'(ovf), 1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("lit_ovf_clr", int'(ovf), 0);
    strobe_rise(8'hE1);
    tick();
    tick();
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    rx_done = 1'b0;
    chk("lit_set_wins", int'(ovf), 1);
    repeat (2) tick();
    drain(last);
    chk("lit_drain_last", int'(last), 8'h0F);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 16; i++) frame(8'(8'h20 + i), 1, 3);
    strobe_rise(8'h55);
    tick();
    tick();
    rd_if.i_Rd_Ready = 1'b1;
    tick();
    rd_if.i_Rd_Ready = 1'b0;
    rx_done = 1'b0;
    chk("lit_pp_count", int'(count), 16);
    chk("lit_pp_ovf", int'(ovf), 0);
    repeat (2) tick();
    drain(last);
    chk("lit_pp_last", int'(last), 8'h55);

    // Random traffic with random ready, wrapping the pointers.
    rand_ready = 1;
    for (int i = 0; i < 40; i++)
      frame(8'($urandom), $urandom_range(1, 4), $urandom_range(3, 6));
    rand_ready = 0;
    rd_if.i_Rd_Ready = 1'b0;
    repeat (3) tick();
    drain(last);

    // Reset mid-burst with a strobe still in the synchronizer.
    for (int i = 0; i < 7; i++) frame(8'(8'h70 + i), 1, 3);
    chk("lit_count7", int'(count), 7);
    strobe_rise(8'h99);
    tick();
    reset = 1'b1;
    #1;
    chk("lit_mid_valid", int'(rd_if.o_Rd_Valid), 0);
    chk("lit_mid_count", int'(count), 0);
    chk("lit_mid_empty", int'(empty), 1);
    chk("lit_mid_full", int'(full), 0);
    chk("lit_mid_ovf", int'(ovf), 0);
    rx_done = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("lit_no_ghost", int'(count), 0);
    chk("lit_no_ghost_v", int'(rd_if.o_Rd_Valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
